accel_host_seq: RTL



---
 rtl/accel_host_seq_pkg.sv | 33 +++
 rtl/accel_host_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/accel_host_seq_pkg.sv
// Shared types and helpers for the accelerator host-side sequencer.
package accel_host_seq_pkg;

  // Sequencer states, walked in order for a normal command.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    READ_REQ  = 3'd4,
    READ_CAP  = 3'd5,
    OUT       = 3'd6,
    RESP      = 3'd7
  } host_seq_state_t;

  // Completion codes reported with rsp_valid.
  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_LEN     = 2'b01,
    RSP_TIMEOUT = 2'b10
  } host_seq_err_t;

  localparam int unsigned OUT_BYTES_W = 6;
  localparam int unsigned OUT_WORDS_W = 5;

  // Number of 32-bit result words needed to cover a byte count (rounded up).
  function automatic logic [OUT_WORDS_W-1:0] bytes_to_words(input logic [OUT_BYTES_W-1:0] nbytes);
    logic [OUT_BYTES_W:0] sum_s;
    sum_s = {1'b0, nbytes} + 7'd3;
    return sum_s[OUT_BYTES_W:2];
  endfunction

endpackage

// File: rtl/accel_host_seq.sv
// Hardware host sequencer for accel_wrapper: loads input words into the
// accelerator memory, runs the start/done handshake, then streams results out.
module accel_host_seq
  import accel_host_seq_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int MEM_DEPTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [$clog2(MEM_DEPTH+1)-1:0]   cmd_in_words,
  input  logic [5:0]                       cmd_out_bytes,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [MEM_DATA_WIDTH-1:0]        in_data,
  output logic                             start,
  input  logic                             done,
  output logic [5:0]                       output_length_byte,
  output logic                             mem_en,
  output logic [MEM_ADDR_WIDTH-1:0]        mem_addr,
  output logic                             mem_we,
  output logic [MEM_DATA_WIDTH/8-1:0]      mem_be,
  output logic [MEM_DATA_WIDTH-1:0]        mem_wdata,
  input  logic [MEM_DATA_WIDTH-1:0]        mem_rdata,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [MEM_DATA_WIDTH-1:0]        out_data,
  output logic                             out_last,
  output logic                             rsp_valid,
  output logic [1:0]                       rsp_err,
  output logic                             busy
);

  localparam int IW = $clog2(MEM_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = MEM_DATA_WIDTH / 8;

  host_seq_state_t             state_r;
  host_seq_err_t               rsp_err_r;
  logic [IW-1:0]               in_words_r;
  logic [IW-1:0]               wr_idx_r;
  logic [OUT_WORDS_W-1:0]      out_words_r;
  logic [OUT_WORDS_W-1:0]      rd_idx_r;
  logic [TW-1:0]               tcnt_r;
  logic [OUT_BYTES_W-1:0]      out_len_r;
  logic                        start_r;
  logic                        mem_en_r;
  logic                        mem_we_r;
  logic [MEM_ADDR_WIDTH-1:0]   mem_addr_r;
  logic [MEM_DATA_WIDTH-1:0]   mem_wdata_r;
  logic [BW-1:0]               mem_be_r;
  logic                        out_valid_r;
  logic                        out_last_r;
  logic [MEM_DATA_WIDTH-1:0]   out_data_r;
  logic                        rsp_valid_r;

  // Handshake readiness and busy are decoded straight from the state.
  assign cmd_ready = (state_r == IDLE);
  assign in_ready  = (state_r == LOAD);
  assign busy      = (state_r != IDLE);

  assign start              = start_r;
  assign output_length_byte = out_len_r;
  assign mem_en             = mem_en_r;
  assign mem_addr           = mem_addr_r;
  assign mem_we             = mem_we_r;
  assign mem_be             = mem_be_r;
  assign mem_wdata          = mem_wdata_r;
  assign out_valid          = out_valid_r;
  assign out_data           = out_data_r;
  assign out_last           = out_last_r;
  assign rsp_valid          = rsp_valid_r;
  assign rsp_err            = rsp_err_r;

  // Sequencer FSM; every externally visible control is registered here and
  // rsp_valid is raised on the edge that enters RESP so it is high during RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rsp_err_r   <= RSP_OK;
      in_words_r  <= {IW{1'b0}};
      wr_idx_r    <= {IW{1'b0}};
      out_words_r <= {OUT_WORDS_W{1'b0}};
      rd_idx_r    <= {OUT_WORDS_W{1'b0}};
      tcnt_r      <= {TW{1'b0}};
      out_len_r   <= {OUT_BYTES_W{1'b0}};
      start_r     <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {MEM_ADDR_WIDTH{1'b0}};
      mem_wdata_r <= {MEM_DATA_WIDTH{1'b0}};
      mem_be_r    <= {BW{1'b1}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {MEM_DATA_WIDTH{1'b0}};
      rsp_valid_r <= 1'b0;
    end else begin
      mem_be_r <= {BW{1'b1}};
      case (state_r)
        IDLE: begin
          rsp_valid_r <= 1'b0;
          if (cmd_valid) begin
            in_words_r  <= cmd_in_words;
            out_len_r   <= cmd_out_bytes;
            out_words_r <= bytes_to_words(cmd_out_bytes);
            if (cmd_in_words > IW'(MEM_DEPTH)) begin
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= RSP_LEN;
              state_r     <= RESP;
            end else if (cmd_in_words == IW'(0)) begin
              state_r <= START;
            end else begin
              state_r <= LOAD;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          if (in_valid) begin
            mem_en_r    <= 1'b1;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= MEM_ADDR_WIDTH'(wr_idx_r);
            mem_wdata_r <= in_data;
            wr_idx_r    <= wr_idx_r + IW'(1);
            if (wr_idx_r == in_words_r - IW'(1)) begin
              state_r <= START;
            end else begin
              state_r <= LOAD;
            end
          end else begin
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
            state_r  <= LOAD;
          end
        end
        START: begin
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          start_r  <= 1'b1;
          tcnt_r   <= {TW{1'b0}};
          state_r  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done) begin
            start_r <= 1'b0;
            if (out_words_r == 5'd0) begin
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= RSP_OK;
              state_r     <= RESP;
            end else begin
              mem_en_r   <= 1'b1;
              mem_we_r   <= 1'b0;
              mem_addr_r <= MEM_ADDR_WIDTH'(rd_idx_r);
              state_r    <= READ_REQ;
            end
          end else if (tcnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
            start_r     <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= RSP_TIMEOUT;
            state_r     <= RESP;
          end else begin
            tcnt_r  <= tcnt_r + TW'(1);
            state_r <= WAIT_DONE;
          end
        end
        READ_REQ: begin
          mem_en_r <= 1'b0;
          state_r  <= READ_CAP;
        end
        READ_CAP: begin
          out_data_r  <= mem_rdata;
          out_valid_r <= 1'b1;
          out_last_r  <= (rd_idx_r == out_words_r - 5'd1);
          state_r     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            if (out_last_r) begin
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= RSP_OK;
              state_r     <= RESP;
            end else begin
              rd_idx_r   <= rd_idx_r + 5'd1;
              mem_en_r   <= 1'b1;
              mem_we_r   <= 1'b0;
              mem_addr_r <= MEM_ADDR_WIDTH'(rd_idx_r + 5'd1);
              state_r    <= READ_REQ;
            end
          end else begin
            state_r <= OUT;
          end
        end
        RESP: begin
          rsp_valid_r <= 1'b0;
          wr_idx_r    <= {IW{1'b0}};
          rd_idx_r    <= {OUT_WORDS_W{1'b0}};
          tcnt_r      <= {TW{1'b0}};
          state_r     <= IDLE;
        end
        default: begin
          start_r     <= 1'b0;
          mem_en_r    <= 1'b0;
          mem_we_r    <= 1'b0;
          out_valid_r <= 1'b0;
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule
